// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface cla_pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage,
// group carry passed stage to stage, whole pipeline stalls together under backpressure.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic               clk,
  input logic               rst,
  cla_pipe_addsub_if.slave  bus
);

  localparam int unsigned STAGES = WIDTH / GROUP;

  // Stage registers: stage k holds operands with groups 0..k-1 already summed into s_q[k].
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             adv;

  logic [WIDTH-1:0] s_nxt    [STAGES];
  logic             grp_cout [STAGES];
  logic             grp_cmsb [STAGES];

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             prod;

  assign adv = !out_valid_q || bus.out_ready;

  // Each bit carry is a flat sum of products from the group carry-in; no ripple.
  always_comb begin
    p    = '0;
    g    = '0;
    c    = '0;
    prod = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      p    = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
      g    = a_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP];
      c    = '0;
      c[0] = c_q[k];
      for (int i = 0; i < GROUP; i++) begin
        prod = c_q[k];
        for (int m = 0; m <= i; m++) begin
          prod = prod & p[m];
        end
        c[i+1] = g[i] | prod;
        for (int j = 0; j < i; j++) begin
          prod = g[j];
          for (int m = j + 1; m <= i; m++) begin
            prod = prod & p[m];
          end
          c[i+1] = c[i+1] | prod;
        end
      end
      s_nxt[k]                    = s_q[k];
      s_nxt[k][k*GROUP +: GROUP]  = p ^ c[GROUP-1:0];
      grp_cout[k]                 = c[GROUP];
      grp_cmsb[k]                 = c[GROUP-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv) begin
      // Subtract is A + ~B + 1; cin only matters in add mode.
      vld_q[0] <= bus.in_valid;
      a_q[0]   <= bus.a;
      b_q[0]   <= bus.b ^ {WIDTH{bus.sub}};
      s_q[0]   <= '0;
      c_q[0]   <= bus.sub | bus.cin;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_nxt[k-1];
        c_q[k]   <= grp_cout[k-1];
      end
      out_valid_q <= vld_q[STAGES-1];
      sum_q       <= s_nxt[STAGES-1];
      cout_q      <= grp_cout[STAGES-1];
      ovf_q       <= grp_cmsb[STAGES-1] ^ grp_cout[STAGES-1];
      zero_q      <= (s_nxt[STAGES-1] == '0);
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: directed spec vectors, backpressure, reset flush
// and a randomized soak against an arithmetic reference model.
module tb_cla_pipe_addsub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;
  localparam int unsigned LAT   = WIDTH / GROUP;

  logic clk = 1'b0;
  logic rst;

  cla_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_addsub #(
    .WIDTH(WIDTH),
    .GROUP(GROUP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_out = 0;
  logic hold  = 1'b0;
  res_t snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    int   ru;
    int   rs;
    if (sub) begin
      ru = int'(a) - int'(b) + 65536;
      rs = int'($signed(a)) - int'($signed(b));
    end else begin
      ru = int'(a) + int'(b) + int'(cin);
      rs = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    r.sum  = ru[15:0];
    r.cout = (ru >= 65536);
    r.ovf  = (rs > 32767) || (rs < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  // Stimulus side of the scoreboard: record every accepted operation.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      n_acc++;
    end
  end

  // Monitor: result ordering/values, stall stability and in_ready protocol.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'({bus.sum, bus.cout, bus.ovf, bus.zero}), 32'(snap));
      end
      check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got sum %0h with nothing outstanding, required none",
                   bus.sum);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("sum", 32'(bus.sum), 32'(e.sum));
          check("cout", 32'(bus.cout), 32'(e.cout));
          check("ovf", 32'(bus.ovf), 32'(e.ovf));
          check("zero", 32'(bus.zero), 32'(e.zero));
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      snap = {bus.sum, bus.cout, bus.ovf, bus.zero};
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int cnt;
    cnt           = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && cnt < bound) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed vectors: a, b, cin, sub -> sum, cout, ovf, zero.
  logic [15:0] da [7] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h7FFF, 16'h8000, 16'h0003, 16'hBEEF};
  logic [15:0] db [7] = '{16'h1111, 16'h0001, 16'hFF00, 16'h0001, 16'h0001, 16'h0005, 16'h0000};
  logic        dc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        ds [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] dsum [7] = '{16'h2345, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'hBEEF};
  logic        dco  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        dov  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        dz   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat;
    int n_before;
    int cyc;
    int target;
    logic [18:0] frozen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_flags", 32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int t = 0; t < 7; t++) begin
      send(da[t], db[t], dc[t], ds[t]);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("dir_latency", 32'(lat), 32'(LAT));
      check("dir_sum", 32'(bus.sum), 32'(dsum[t]));
      check("dir_cout", 32'(bus.cout), 32'(dco[t]));
      check("dir_ovf", 32'(bus.ovf), 32'(dov[t]));
      check("dir_zero", 32'(bus.zero), 32'(dz[t]));
      @(posedge clk);
      #1;
    end

    // Backpressure: six back-to-back ops, then a three-cycle stall with a result waiting.
    n_before      = n_out;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.cin      = 1'($urandom);
      bus.sub      = 1'($urandom);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    frozen = {bus.sum, bus.cout, bus.ovf, bus.zero};
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_frozen", 32'({bus.sum, bus.cout, bus.ovf, bus.zero}), 32'(frozen));
    end
    @(posedge clk);
    #1;
    drain(40);
    check("bp_result_count", 32'(n_out - n_before), 32'd6);

    // Reset with three operations in flight; none may ever emerge.
    n_before = n_out;
    for (int i = 0; i < 3; i++) begin
      send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    end
    bus.a        = 16'h5555;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("flush_no_results", 32'(n_out - n_before), 32'd0);

    // Random soak with random input gaps and output backpressure.
    target = n_acc + 10000;
    cyc    = 0;
    while (n_acc < target && cyc < 60000) begin
      bus.a         = 16'($urandom);
      bus.b         = ($urandom_range(0, 7) == 0) ? 16'hFFFF - bus.a : 16'($urandom);
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check("soak_accepts", 32'(n_acc >= target), 32'd1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
